// File: rtl/axis_patgen_pkg.sv
// axis_patgen_pkg
// Shared types and constants for the AXI-Stream pattern generator:
//   state_t        controller states
//   mode_t         pattern select encoding
//   lfsr_taps()    Galois (right-shift) feedback mask giving a maximal-length
//                  sequence for the supported data widths
package axis_patgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  // Masks are the tap sets x^n + ... + 1 with bit (tap-1) set.
  localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_D008;
  localparam logic [63:0] LFSR_TAPS_24 = 64'h0000_0000_00E1_0000;
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] LFSR_TAPS_40 = 64'h0000_00A0_0014_0000;
  localparam logic [63:0] LFSR_TAPS_48 = 64'h0000_C000_0018_0000;
  localparam logic [63:0] LFSR_TAPS_56 = 64'h00C0_0006_0000_0000;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      24:      return LFSR_TAPS_24;
      32:      return LFSR_TAPS_32;
      40:      return LFSR_TAPS_40;
      48:      return LFSR_TAPS_48;
      56:      return LFSR_TAPS_56;
      64:      return LFSR_TAPS_64;
      // Other widths fall back to taps at the top two bits.
      default: return (64'd3 << (width - 2));
    endcase
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// axi_stream_inf
// Minimal AXI-Stream bundle: tvalid, tdata[DSIZE], tlast, tuser[USIZE]
// driven by the master, tready driven by the slave.
interface axi_stream_inf #(
  parameter int DSIZE = 16,
  parameter int USIZE = 1
);
  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic             tlast;
  logic [USIZE-1:0] tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/patgen_lfsr.sv
// patgen_lfsr
// One combinational step of a Galois right-shift LFSR using the package tap
// mask for DSIZE. Built only when AXIS_PATGEN_LFSR_EN is defined.
// Ports:
//   cur  input  [DSIZE-1:0]  current LFSR value
//   nxt  output [DSIZE-1:0]  value after one step
`ifdef AXIS_PATGEN_LFSR_EN
module patgen_lfsr
  import axis_patgen_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic [DSIZE-1:0] cur,
  output logic [DSIZE-1:0] nxt
);
  localparam logic [63:0] TAPS = lfsr_taps(DSIZE);

  always_comb begin
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ TAPS[DSIZE-1:0];
  end
endmodule
`endif

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen
// AXI-Stream test-pattern source: emits frames of constant, ramp or LFSR data
// with start-of-frame on tuser[0] and tlast on the final beat, optional idle
// gap between frames, and a frame-count / graceful-stop run controller.
// Build option: AXIS_PATGEN_LFSR_EN enables the LFSR pattern (mode 2);
// without it mode 2 produces a ramp and no LFSR logic exists.
// Ports:
//   clock, rst_n          clock and async active-low reset
//   start, stop           run request (IDLE only) / graceful abort
//   mode, seed            pattern select and initial value
//   frame_len, frame_num  beats per frame (0 -> 1), frames per run (0 -> until stop)
//   origin_inf            AXI-Stream master
//   busy, done, frame_cnt status
//
// state   | meaning
// IDLE    | waiting for start; frame_cnt holds last run's count
// RUN     | tvalid high, beats transfer on tready
// GAP     | GAP idle cycles between frames
// DONE    | one-cycle done pulse, then back to IDLE
module axis_pattern_gen
  import axis_patgen_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int USIZE = 1,
  parameter int GAP   = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DSIZE-1:0]  seed,
  input  logic [15:0]       frame_len,
  input  logic [15:0]       frame_num,
  axi_stream_inf.master     origin_inf,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           state;
  mode_t            mode_r;
  logic [15:0]      len_r;
  logic [15:0]      num_r;
  logic [15:0]      beat_cnt;
  logic [7:0]       gap_cnt;
  logic             stop_seen;
  logic             finish_r;
  logic [DSIZE-1:0] data_r;
  logic             tvalid_r;
  logic             tlast_r;
  logic             sof_r;

  logic [DSIZE-1:0] data_next;
  logic [DSIZE-1:0] seed_init;
  logic [15:0]      len_in;
  logic [15:0]      last_idx;
  logic [15:0]      frame_cnt_inc;
  logic             finishing;
  logic [USIZE-1:0] tuser_w;

`ifdef AXIS_PATGEN_LFSR_EN
  logic [DSIZE-1:0] lfsr_next;

  patgen_lfsr #(.DSIZE(DSIZE)) u_lfsr (
    .cur (data_r),
    .nxt (lfsr_next)
  );
`endif

  always_comb begin
    data_next = data_r + DSIZE'(1);
    case (mode_r)
      MODE_CONST: data_next = data_r;
`ifdef AXIS_PATGEN_LFSR_EN
      MODE_LFSR:  data_next = lfsr_next;
`endif
      default:    ;
    endcase
  end

  // An all-zero LFSR would lock up, so a zero seed starts from all-ones.
  always_comb begin
    seed_init = seed;
`ifdef AXIS_PATGEN_LFSR_EN
    if (mode_t'(mode) == MODE_LFSR && seed == '0) seed_init = '1;
`endif
  end

  assign len_in        = (frame_len == 16'd0) ? 16'd1 : frame_len;
  assign last_idx      = len_r - 16'd1;
  assign frame_cnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
  // A stop arriving on the tlast handshake cycle itself also ends the run.
  assign finishing     = ((num_r != 16'd0) && (frame_cnt == num_r - 16'd1)) || stop_seen || stop;

  always_comb begin
    tuser_w    = '0;
    tuser_w[0] = sof_r;
  end

  assign origin_inf.tvalid = tvalid_r;
  assign origin_inf.tdata  = data_r;
  assign origin_inf.tlast  = tlast_r;
  assign origin_inf.tuser  = tuser_w;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_r    <= MODE_CONST;
      len_r     <= 16'd1;
      num_r     <= 16'd0;
      beat_cnt  <= 16'd0;
      gap_cnt   <= 8'd0;
      stop_seen <= 1'b0;
      finish_r  <= 1'b0;
      data_r    <= '0;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      sof_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      if (state != ST_IDLE && stop) stop_seen <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            mode_r    <= mode_t'(mode);
            len_r     <= len_in;
            num_r     <= frame_num;
            data_r    <= seed_init;
            beat_cnt  <= 16'd0;
            frame_cnt <= 16'd0;
            stop_seen <= 1'b0;
            finish_r  <= 1'b0;
            tvalid_r  <= 1'b1;
            sof_r     <= 1'b1;
            tlast_r   <= (len_in == 16'd1);
            busy      <= 1'b1;
          end
        end

        ST_RUN: begin
          if (tvalid_r && origin_inf.tready) begin
            data_r <= data_next;
            if (beat_cnt == last_idx) begin
              beat_cnt  <= 16'd0;
              frame_cnt <= frame_cnt_inc;
              if (GAP > 0) begin
                state    <= ST_GAP;
                gap_cnt  <= GAP_LOAD;
                finish_r <= finishing;
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
                sof_r    <= 1'b0;
              end else if (finishing) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
                sof_r    <= 1'b0;
              end else begin
                sof_r   <= 1'b1;
                tlast_r <= (len_r == 16'd1);
              end
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
              sof_r    <= 1'b0;
              tlast_r  <= (beat_cnt + 16'd1 == last_idx);
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            if (finish_r || stop_seen) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_RUN;
              tvalid_r <= 1'b1;
              sof_r    <= 1'b1;
              tlast_r  <= (len_r == 16'd1);
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          stop_seen <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pattern_gen.sv
module tb_axis_pattern_gen;

  localparam logic [15:0] TAPS16 = 16'hD008;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, stop, tready;
  logic [1:0]  mode;
  logic [15:0] seed, frame_len, frame_num;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] fcnt_a, fcnt_b;

  axi_stream_inf #(.DSIZE(16), .USIZE(1)) axa ();
  axi_stream_inf #(.DSIZE(16), .USIZE(1)) axb ();
  assign axa.tready = tready;
  assign axb.tready = tready;

  axis_pattern_gen #(.DSIZE(16), .USIZE(1), .GAP(0)) dut_a (
    .clock(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .mode(mode),
    .seed(seed), .frame_len(frame_len), .frame_num(frame_num),
    .origin_inf(axa), .busy(busy_a), .done(done_a), .frame_cnt(fcnt_a));

  axis_pattern_gen #(.DSIZE(16), .USIZE(1), .GAP(3)) dut_b (
    .clock(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .mode(mode),
    .seed(seed), .frame_len(frame_len), .frame_num(frame_num),
    .origin_inf(axb), .busy(busy_b), .done(done_b), .frame_cnt(fcnt_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: next pattern value from the pattern rules.
  function automatic logic [15:0] next_val(input logic [1:0] m, input logic [15:0] d);
    if (m == 2'd0) return d;
`ifdef AXIS_PATGEN_LFSR_EN
    if (m == 2'd2) return d[0] ? ((d >> 1) ^ TAPS16) : (d >> 1);
`endif
    return d + 16'd1;
  endfunction

  // Monitor on dut_a: record handshakes, done pulses, and hold-while-stalled.
  logic [15:0] q_data[$];
  bit          q_last[$];
  bit          q_user[$];
  int          cyc = 0, last_hs_cyc = 0, done_cyc = 0, done_cnt_a = 0;
  bit          stall_prev = 0;
  logic [17:0] prev_out;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (axa.tvalid && axa.tready) begin
      q_data.push_back(axa.tdata);
      q_last.push_back(axa.tlast);
      q_user.push_back(axa.tuser[0]);
      last_hs_cyc = cyc;
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc = cyc;
    end
    if (stall_prev && rst_n && axa.tvalid)
      check("hold", {axa.tdata, axa.tlast, axa.tuser[0]}, prev_out);
    stall_prev = rst_n && axa.tvalid && !axa.tready;
    prev_out   = {axa.tdata, axa.tlast, axa.tuser[0]};
  end

  task automatic check_beats(input logic [1:0] m, input logic [15:0] s, input logic [15:0] l,
                             input int frames);
    int len;
    int total;
    logic [15:0] d;
    len   = (l == 16'd0) ? 1 : int'(l);
    total = frames * len;
    d     = s;
`ifdef AXIS_PATGEN_LFSR_EN
    if (m == 2'd2 && s == 16'd0) d = 16'hFFFF;
`endif
    check("beat_count", q_data.size(), total);
    for (int i = 0; i < total && i < q_data.size(); i++) begin
      check($sformatf("beat%0d", i), {q_data[i], q_last[i], q_user[i]},
            {d, (i % len) == len - 1, (i % len) == 0});
      d = next_val(m, d);
    end
  endtask

  // rdy: 0 always ready, 1 random, 2 toggling. stop_at: handshake count at
  // which stop is pulsed (-1 never). rnd_start: throw ignored start pulses.
  task automatic run_a(input logic [1:0] m, input logic [15:0] s, input logic [15:0] l,
                       input logic [15:0] n, input int rdy, input int stop_at, input bit rnd_start);
    int base;
    bit ok;
    bit stopped;
    q_data.delete(); q_last.delete(); q_user.delete();
    base = done_cnt_a;
    ok = 0;
    stopped = 0;
    @(negedge clk);
    mode = m; seed = s; frame_len = l; frame_num = n; start_a = 1'b1; tready = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    mode = 2'($urandom); seed = 16'($urandom);
    frame_len = 16'($urandom); frame_num = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      case (rdy)
        0:       tready = 1'b1;
        1:       tready = 1'($urandom);
        default: tready = c[0];
      endcase
      start_a = rnd_start ? ($urandom_range(0, 7) == 0) : 1'b0;
      stop = (stop_at >= 0 && q_data.size() == stop_at && !stopped);
      if (stop) stopped = 1;
      #2;
      if (done_cnt_a != base) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    stop = 1'b0;
    tready = 1'b1;
    check("done_seen", ok, 1);
    repeat (3) @(negedge clk);
    #2;
    check("done_once", done_cnt_a - base, 1);
    check("busy_idle", busy_a, 0);
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [15:0] s;
    logic [15:0] l;
    logic [15:0] n;
    int          rdy;
    int          beats;
    logic [15:0] first;
    logic [15:0] lastd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2'd1, 16'hFFFE, 16'd4, 16'd2, 0, 8, 16'hFFFE, 16'h0005, 16'd2};
    vecs[1] = '{2'd0, 16'hA5A5, 16'd3, 16'd1, 2, 3, 16'hA5A5, 16'hA5A5, 16'd1};
    vecs[2] = '{2'd1, 16'h1234, 16'd0, 16'd1, 0, 1, 16'h1234, 16'h1234, 16'd1};
    vecs[3] = '{2'd3, 16'h00FF, 16'd2, 16'd3, 0, 6, 16'h00FF, 16'h0104, 16'd3};
`ifdef AXIS_PATGEN_LFSR_EN
    vecs[4] = '{2'd2, 16'h0000, 16'd3, 16'd1, 0, 3, 16'hFFFF, 16'h87F3, 16'd1};
`else
    vecs[4] = '{2'd2, 16'h0000, 16'd3, 16'd1, 0, 3, 16'h0000, 16'h0002, 16'd1};
`endif

    rst_n = 1'b0; start_a = 0; start_b = 0; stop = 0; tready = 1;
    mode = 0; seed = 0; frame_len = 0; frame_num = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("rst_tvalid", axa.tvalid, 0);
    check("rst_tdata", axa.tdata, 0);
    check("rst_tlast", axa.tlast, 0);
    check("rst_tuser", axa.tuser, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_fcnt", fcnt_a, 0);
    check("rst_b_tvalid", axb.tvalid, 0);

    // Table-driven runs.
    foreach (vecs[k]) begin
      run_a(vecs[k].m, vecs[k].s, vecs[k].l, vecs[k].n, vecs[k].rdy, -1, 0);
      check($sformatf("v%0d_beats", k), q_data.size(), vecs[k].beats);
      check($sformatf("v%0d_first", k), (q_data.size() > 0) ? q_data[0] : 16'hDEAD, vecs[k].first);
      check($sformatf("v%0d_lastd", k), (q_data.size() > 0) ? q_data[$] : 16'hDEAD, vecs[k].lastd);
      check($sformatf("v%0d_fcnt", k), fcnt_a, vecs[k].cnt);
      check_beats(vecs[k].m, vecs[k].s, vecs[k].l, int'(vecs[k].n));
      if (vecs[k].rdy == 0) check($sformatf("v%0d_done_lat", k), done_cyc - last_hs_cyc, 1);
    end

    // Stop in IDLE is ignored: the following run still does both frames.
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    run_a(2'd1, 16'h0040, 16'd2, 16'd2, 0, -1, 0);
    check("idle_stop_fcnt", fcnt_a, 2);
    check_beats(2'd1, 16'h0040, 16'd2, 2);

    // Unlimited run, stop during beat 2 of frame 3 -> frame 3 completes.
    run_a(2'd1, 16'h0300, 16'd5, 16'd0, 0, 11, 0);
    check("stop_fcnt", fcnt_a, 3);
    check_beats(2'd1, 16'h0300, 16'd5, 3);

    // Gap instance: 3 idle cycles between frames, busy high throughout.
    begin
      int hs, lows, phase, busy_low;
      bit seen;
      hs = 0; lows = 0; phase = 0; busy_low = 0; seen = 0;
      @(negedge clk);
      tready = 1; mode = 2'd1; seed = 16'h0010; frame_len = 16'd2; frame_num = 16'd2;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
        #2;
        if (axb.tvalid) begin
          hs++;
          if (phase == 1) phase = 2;
        end else if (phase == 0 && hs > 0) begin
          phase = 1;
          lows = 1;
        end else if (phase == 1) begin
          lows++;
        end
        if (done_b) seen = 1;
        else if (!busy_b) busy_low++;
        @(negedge clk);
      end
      check("gap_done", seen, 1);
      check("gap_lows", lows, 3);
      check("gap_beats", hs, 4);
      check("gap_busy_low", busy_low, 0);
      check("gap_fcnt", fcnt_b, 2);
    end

    // Reset in the middle of a frame, then a fresh run from seed.
    q_data.delete(); q_last.delete(); q_user.delete();
    @(negedge clk);
    tready = 1; mode = 2'd1; seed = 16'h0100; frame_len = 16'd4; frame_num = 16'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 20 && q_data.size() < 1; c++) @(negedge clk);
    check("pre_rst_tvalid", axa.tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", axa.tvalid, 0);
    check("mid_rst_tdata", axa.tdata, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_fcnt", fcnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(2'd1, 16'h0100, 16'd4, 16'd1, 0, -1, 0);
    check("post_rst_fcnt", fcnt_a, 1);
    check_beats(2'd1, 16'h0100, 16'd4, 1);

    // Randomized runs with random backpressure and ignored start pulses.
    for (int r = 0; r < 12; r++) begin
      logic [1:0]  m;
      logic [15:0] s, l, n;
      m = 2'($urandom_range(0, 3));
      s = 16'($urandom);
      l = 16'($urandom_range(0, 5));
      n = 16'($urandom_range(1, 3));
      run_a(m, s, l, n, 1, -1, 1);
      check($sformatf("rnd%0d_fcnt", r), fcnt_a, n);
      check_beats(m, s, l, int'(n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
